// File: rtl/button_conditioner_if.sv
// Signal bundle between a raw button input and its conditioned outputs.
// The DUT uses the slave modport and the environment uses the master modport.
interface button_conditioner_if;
  // There is no valid/ready handshake on this bundle. The rise and fall
  // signals act as single-cycle event qualifiers: each is high for exactly one
  // clock when the debounced level changes. The level, q and press_count
  // signals are registered and hold steady between those events.
  logic       d;
  logic       level;
  logic       rise;
  logic       fall;
  logic       q;
  logic [7:0] press_count;
  logic [1:0] dbg_state;

  modport master (
    output d,
    input  level, rise, fall, q, press_count, dbg_state
  );

  modport slave (
    input  d,
    output level, rise, fall, q, press_count, dbg_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw button input. It produces a clean level,
// one-cycle edge pulses, a toggle output and an 8-bit press counter.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be 1..255");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_q;
  logic [7:0]             r_press_count;

  state_t                 w_state_next;
  logic [7:0]             w_cnt_next;
  logic                   w_rise_next;
  logic                   w_fall_next;
  logic                   w_level_next;
  logic                   w_s;

  // Only the last synchronizer stage is safe to use in downstream logic.
  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.d};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STABLE_LOW;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = 8'd0;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    unique case (r_state)
      STABLE_LOW: begin
        if (w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_next = STABLE_HIGH;
            w_rise_next  = 1'b1;
          end else begin
            w_state_next = WAIT_HIGH;
            w_cnt_next   = 8'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          w_state_next = STABLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = STABLE_HIGH;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_next = STABLE_LOW;
            w_fall_next  = 1'b1;
          end else begin
            w_state_next = WAIT_LOW;
            w_cnt_next   = 8'd1;
          end
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_state_next = STABLE_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = STABLE_LOW;
          w_fall_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = STABLE_LOW;
      end
    endcase
  end

  // The level follows the next state, so it changes on the same edge that
  // the FSM commits to a new stable value.
  assign w_level_next = (w_state_next == STABLE_HIGH) || (w_state_next == WAIT_LOW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level       <= 1'b0;
      r_rise        <= 1'b0;
      r_fall        <= 1'b0;
      r_q           <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      if (w_rise_next) begin
        r_q           <= ~r_q;
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign bus.level       = r_level;
  assign bus.rise        = r_rise;
  assign bus.fall        = r_fall;
  assign bus.q           = r_q;
  assign bus.press_count = r_press_count;
  assign bus.dbg_state   = r_state;

endmodule
